uart_rx_assembler: RTL and testbench

Receive-side counterpart of the uart-to-reg word transmitter: collects consecutive N-bit bytes strobed out of the UART RX module and assembles them, most-significant byte first, into an M-bit register. Sits between the UART RX byte interface and the register consumer. Flags a one-cycle `word_valid` when a full word lands. Discards partial words on framing error or an inter-byte timeout so the stream re-synchronises.

---
 rtl/uart_rx_assembler_if.sv | 23 ++
 rtl/uart_rx_assembler.sv | 82 ++++++++
 tb/tb_uart_rx_assembler.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_assembler_if.sv
// Byte-in / word-out bundle between the UART RX byte strobe and the register consumer.
// The slave side is the assembler itself. The master side is whoever feeds bytes and reads words.
interface uart_rx_assembler_if #(
    parameter int N = 8,
    parameter int M = 16
);
    logic         rx_valid;
    logic [N-1:0] rx_data;
    logic         rx_error;
    logic [M-1:0] word;
    logic         word_valid;
    logic         drop;

    modport slave (
        input  rx_valid, rx_data, rx_error,
        output word, word_valid, drop
    );

    modport master (
        output rx_valid, rx_data, rx_error,
        input  word, word_valid, drop
    );
endinterface

// File: rtl/uart_rx_assembler.sv
// Assembles BYTES consecutive RX bytes into one M-bit word, most significant byte first.
// A partial word is dropped on a framing error or when the gap between bytes grows too long.
module uart_rx_assembler #(
    parameter int N       = 8,
    parameter int M       = 16,
    parameter int TIMEOUT = 1000
) (
    input  logic               clk,
    input  logic               reset,
    uart_rx_assembler_if.slave bus
);
    localparam int BYTES = M / N;
    localparam int CW    = $clog2(BYTES);
    localparam int TW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BYTES - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t          state;
    logic [M-N-1:0]  acc;
    logic [CW-1:0]   cnt;
    logic [TW-1:0]   tmo;
    logic [M-1:0]    shifted;

    // The low M-N bits are the accumulator after the shift. The full value is the finished word.
    assign shifted = {acc, bus.rx_data};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            acc            <= '0;
            cnt            <= '0;
            tmo            <= '0;
            bus.word       <= '0;
            bus.word_valid <= 1'b0;
            bus.drop       <= 1'b0;
        end else begin
            bus.word_valid <= 1'b0;
            bus.drop       <= 1'b0;
            case (state)
                IDLE: begin
                    // An error with no partial word has nothing to discard.
                    if (bus.rx_valid) begin
                        acc   <= shifted[M-N-1:0];
                        cnt   <= CW'(1);
                        tmo   <= '0;
                        state <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (bus.rx_error) begin
                        cnt      <= '0;
                        tmo      <= '0;
                        bus.drop <= 1'b1;
                        state    <= IDLE;
                    end else if (bus.rx_valid) begin
                        tmo <= '0;
                        if (cnt == CNT_LAST) begin
                            bus.word       <= shifted;
                            bus.word_valid <= 1'b1;
                            cnt            <= '0;
                            state          <= IDLE;
                        end else begin
                            acc <= shifted[M-N-1:0];
                            cnt <= cnt + 1'b1;
                        end
                    end else if (TIMEOUT != 0 && tmo == TMO_LAST) begin
                        // Valid is tested first, so a byte arriving on the expiry edge still counts.
                        cnt      <= '0;
                        tmo      <= '0;
                        bus.drop <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_assembler.sv
// Scoreboard bench: a byte-list model predicts each word/drop event and its cycle,
// and a separate monitor compares the DUT against those predictions.
module tb_uart_rx_assembler;
    localparam int N  = 8;
    localparam int M  = 16;
    localparam int TO = 20;
    localparam int BYTES = M / N;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    uart_rx_assembler_if #(.N(N), .M(M)) bus ();

    uart_rx_assembler #(.N(N), .M(M), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        int           cyc;
        bit           is_word;
        logic [M-1:0] w;
    } exp_t;

    exp_t         q[$];
    logic [N-1:0] part[$];
    int           idle_cnt = 0;
    logic [M-1:0] cur_word = '0;
    int           cyc = 0;
    bit           mon_en = 1'b0;
    int           checks = 0;
    int           errors = 0;

    always @(posedge clk) cyc++;

    function automatic logic [M-1:0] join_bytes();
        logic [M-1:0] w = '0;
        foreach (part[i]) w = (w << N) | M'(part[i]);
        return w;
    endfunction

    // Model of what the upcoming edge (cycle cyc+1) produces for this input set.
    task automatic model_step(input bit v, input bit e, input logic [N-1:0] d);
        exp_t x;
        x.cyc = cyc + 1;
        x.w   = '0;
        if (part.size() == 0) begin
            if (v) begin
                part.push_back(d);
                idle_cnt = 0;
            end
        end else if (e) begin
            x.is_word = 1'b0;
            q.push_back(x);
            part.delete();
        end else if (v) begin
            part.push_back(d);
            idle_cnt = 0;
            if (part.size() == BYTES) begin
                x.is_word = 1'b1;
                x.w       = join_bytes();
                q.push_back(x);
                part.delete();
            end
        end else begin
            idle_cnt++;
            if (idle_cnt == TO) begin
                x.is_word = 1'b0;
                q.push_back(x);
                part.delete();
            end
        end
    endtask

    task automatic drive(input bit v, input bit e, input logic [N-1:0] d);
        @(negedge clk);
        bus.rx_valid = v;
        bus.rx_error = e;
        bus.rx_data  = d;
        model_step(v, e, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0);
    endtask

    task automatic model_reset();
        q.delete();
        part.delete();
        idle_cnt = 0;
        cur_word = '0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                checks++;
                if (e.cyc != cyc) begin
                    errors++;
                    $display("FAIL event_timing: expected event at cycle %0d not seen (now %0d)", e.cyc, cyc);
                end else if (e.is_word) begin
                    if (!bus.word_valid || bus.drop || bus.word !== e.w) begin
                        errors++;
                        $display("FAIL word_event cyc %0d: got valid=%b drop=%b word=%h, want valid=1 drop=0 word=%h",
                                 cyc, bus.word_valid, bus.drop, bus.word, e.w);
                    end
                end else if (!bus.drop || bus.word_valid) begin
                    errors++;
                    $display("FAIL drop_event cyc %0d: got drop=%b valid=%b, want drop=1 valid=0",
                             cyc, bus.drop, bus.word_valid);
                end
                if (e.is_word) cur_word = e.w;
            end else begin
                checks++;
                if (bus.word_valid !== 1'b0 || bus.drop !== 1'b0) begin
                    errors++;
                    $display("FAIL spurious cyc %0d: got valid=%b drop=%b, want 0/0", cyc, bus.word_valid, bus.drop);
                end
            end
            checks++;
            if (bus.word !== cur_word) begin
                errors++;
                $display("FAIL word_hold cyc %0d: got %h, want %h", cyc, bus.word, cur_word);
            end
        end
    end

    task automatic check_zero(input string name);
        checks++;
        if (bus.word !== '0 || bus.word_valid !== 1'b0 || bus.drop !== 1'b0) begin
            errors++;
            $display("FAIL %s: got word=%h valid=%b drop=%b, want 0/0/0",
                     name, bus.word, bus.word_valid, bus.drop);
        end
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_error = 1'b0;
        bus.rx_data  = '0;

        // Reset held while the RX side keeps strobing.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.rx_valid = i[0];
            bus.rx_data  = N'(8'h30 + i);
            check_zero("reset_hold");
        end
        @(negedge clk);
        bus.rx_valid = 1'b0;
        model_reset();
        reset  = 1'b1;
        mon_en = 1'b1;
        idle(5);

        // Basic word, strobes 10 cycles apart, then hold.
        drive(1'b1, 1'b0, 8'h41);
        idle(9);
        drive(1'b1, 1'b0, 8'h42);
        idle(50);

        // Back-to-back words.
        drive(1'b1, 1'b0, 8'h11);
        drive(1'b1, 1'b0, 8'h22);
        drive(1'b1, 1'b0, 8'h33);
        drive(1'b1, 1'b0, 8'h44);
        idle(3);

        // Timeout expiry, then recovery.
        drive(1'b1, 1'b0, 8'hAA);
        idle(TO);
        idle(2);
        drive(1'b1, 1'b0, 8'h12);
        drive(1'b1, 1'b0, 8'h34);
        idle(3);

        // Second byte lands exactly on the expiry edge.
        drive(1'b1, 1'b0, 8'hAA);
        idle(TO - 1);
        drive(1'b1, 1'b0, 8'h55);
        idle(TO + 2);

        // Error with a simultaneous byte, then recovery, then an error while idle.
        drive(1'b1, 1'b0, 8'h41);
        drive(1'b1, 1'b1, 8'h42);
        drive(1'b1, 1'b0, 8'h43);
        drive(1'b1, 1'b0, 8'h44);
        idle(2);
        drive(1'b0, 1'b1, 8'h00);
        idle(3);

        // Asynchronous reset between edges in the middle of a word.
        drive(1'b1, 1'b0, 8'h41);
        drive(1'b0, 1'b0, 8'h00);
        #2;
        reset  = 1'b0;
        mon_en = 1'b0;
        #1;
        check_zero("async_reset");
        @(negedge clk);
        check_zero("reset_after_edge");
        model_reset();
        reset  = 1'b1;
        mon_en = 1'b1;
        drive(1'b1, 1'b0, 8'h42);
        drive(1'b1, 1'b0, 8'h43);
        idle(3);

        // Random traffic with occasional errors and long gaps.
        for (int t = 0; t < 400; t++) begin
            int gap;
            bit v, e;
            gap = ($urandom_range(0, 7) == 0) ? $urandom_range(TO - 3, TO + 3) : $urandom_range(0, 3);
            idle(gap);
            e = ($urandom_range(0, 9) == 0);
            v = ($urandom_range(0, 9) != 0);
            drive(v, e, N'($urandom));
        end
        idle(TO + 10);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d events still pending, want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
